// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB wait-state completer.
//   apb_state_e       - transfer FSM states (idle / counting waits / ready)
//   CntWidth          - wait-state counter width (supports 0..15 waits)
//   APB_RDATA_DEFAULT - value driven on Prdata when no valid read data
package apb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StReady
    } apb_state_e;

    localparam int unsigned CntWidth          = 4;
    localparam int unsigned APB_RDATA_DEFAULT = 0;

endpackage

// File: rtl/apb_wait_slave_if.sv
// apb_wait_slave_if: APB bus bundle between one master and the wait-state completer.
//   Psel, Penable, Pwrite, Paddr, Pwdata : master -> slave request signals
//   Prdata, Pready, Pslverr              : slave -> master response signals
// Modports: master (drives request), slave (drives response).
interface apb_wait_slave_if #(
    parameter int unsigned ADD_WIDTH = 8,
    parameter int unsigned WIDTH     = 32
) ();

    logic                 Psel;
    logic                 Penable;
    logic                 Pwrite;
    logic [ADD_WIDTH-1:0] Paddr;
    logic [WIDTH-1:0]     Pwdata;
    logic [WIDTH-1:0]     Prdata;
    logic                 Pready;
    logic                 Pslverr;

    modport master (
        output Psel, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Psel, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );

endinterface

// File: rtl/apb_regfile.sv
// apb_regfile: DEPTH x WIDTH register array.
//   clk_i   - clock
//   clr_i   - synchronous clear of every entry (wins over a write)
//   we_i    - write enable; waddr_i/wdata_i written on the rising edge
//   raddr_i - asynchronous read address, rdata_o - read data
module apb_regfile #(
    parameter int unsigned  DEPTH = 64,
    parameter int unsigned  WIDTH = 32,
    localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [IdxW-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IdxW-1:0]  raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB completer with a word-addressed register file and a fixed
// number of wait states (WAIT_CYCLES) inserted before Pready.
//   Pclk    - clock, rising edge
//   Presetn - synchronous, active-high reset (name kept from the bus codebase)
//   bus     - apb_wait_slave_if.slave: Psel/Penable/Pwrite/Paddr/Pwdata in,
//             Prdata/Pready/Pslverr out (all outputs registered)
// Optional feature: define APB_SLVERR_EN to report out-of-range accesses on
// Pslverr; otherwise Pslverr is tied low and such accesses are silently dropped.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter int unsigned ADD_WIDTH   = 8,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic             Pclk,
    input logic             Presetn,
    apb_wait_slave_if.slave bus
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e           state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 write_q, write_d;
    logic [ADD_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic                 err_q, err_d;
    logic                 pready_q, pready_d;
    logic [WIDTH-1:0]     prdata_q, prdata_d;
    logic [WIDTH-1:0]     rd_data;
    logic                 setup, access, commit;

    assign setup  = bus.Psel && !bus.Penable;
    assign access = bus.Psel && bus.Penable;
    assign commit = (state_q == StReady) && access && write_q && !err_q;

    // State / request / counter register.
    always_ff @(posedge Pclk) begin
        if (Presetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. The request is captured once in setup; the bus address
    // and data are not looked at again until the FSM is back in idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    write_d = bus.Pwrite;
                    addr_d  = bus.Paddr;
                    wdata_d = bus.Pwdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StReady;
                        cnt_d   = '0;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntWidth'(WAIT_CYCLES);
                    end
                end
                err_d = (33'(addr_d) >= 33'(DEPTH));
            end
            StWait: begin
                if (!bus.Psel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (bus.Penable) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CntWidth'(1)) begin
                        state_d = StReady;
                    end
                end
            end
            StReady: begin
                // Completion (Psel & Penable) and abort (!Psel) both end in idle.
                if (!bus.Psel || bus.Penable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: computed from next state so the bus outputs are registered.
    always_comb begin
        pready_d = (state_d == StReady);
        prdata_d = WIDTH'(APB_RDATA_DEFAULT);
        if ((state_d == StReady) && !write_d && !err_d) begin
            prdata_d = rd_data;
        end
    end

    always_ff @(posedge Pclk) begin
        if (Presetn) begin
            pready_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            pready_q <= pready_d;
            prdata_q <= prdata_d;
        end
    end

    assign bus.Pready = pready_q;
    assign bus.Prdata = prdata_q;

`ifdef APB_SLVERR_EN
    logic pslverr_q;

    always_ff @(posedge Pclk) begin
        if (Presetn) begin
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= (state_d == StReady) && err_d;
        end
    end

    assign bus.Pslverr = pslverr_q;
`else
    assign bus.Pslverr = 1'b0;
`endif

    apb_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk_i   (Pclk),
        .clr_i   (Presetn),
        .we_i    (commit),
        .waddr_i (addr_q[IdxW-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (addr_d[IdxW-1:0]),
        .rdata_o (rd_data)
    );

endmodule

// File: doc/apb_wait_slave.md
# apb_wait_slave

APB completer holding a small word-addressed register file, with a programmable number of wait states inserted via `Pready`. It sits directly downstream of the APB master, on the same `Psel`/`Penable`/`Pwrite`/`Paddr`/`Pwdata`/`Prdata`/`Pready` bus, and is the second slave on that bus. It exercises the master's wait-state handling that a zero-wait slave never triggers.

## Interface
Parameters:
- `ADD_WIDTH`, default 8: width of `Paddr`.
- `WIDTH`, default 32: data width.
- `DEPTH`, default 64: number of registers; power of two, at most 2^ADD_WIDTH.
- `WAIT_CYCLES`, default 2: wait states per transfer, 0–15.

Ports:
- `Pclk`  in  1  clock; all logic is on the rising edge.
- `Presetn`  in  1  reset; one clock, reset is synchronous and active-high; the port keeps the codebase name.
- `Psel`  in  1  slave select.
- `Penable`  in  1  access phase.
- `Pwrite`  in  1  1 = write, 0 = read.
- `Paddr`  in  ADD_WIDTH  word address.
- `Pwdata`  in  WIDTH  write data.
- `Prdata`  out  WIDTH  read data; valid only while `Pready`=1 on a read.
- `Pready`  out  1  transfer-complete strobe.
- `Pslverr`  out  1  error flag, qualified by `Pready`.

## Operation
- States:
  - IDLE: no transfer in progress.
  - WAIT: counting wait states.
  - READY: `Pready` high, waiting for the completing edge.
- IDLE → (`Psel`=1, `Penable`=0, i.e. setup phase):
  - Latch `Pwrite`, `Paddr`, `Pwdata` into request registers; the bus is not sampled again for this transfer.
  - Set error flag = (`Paddr` ≥ DEPTH).
  - If WAIT_CYCLES=0, go to READY. Otherwise load the counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - Each edge with `Psel`=`Penable`=1: counter −1. When the counter reaches 0, go to READY.
  - `Psel`=0 at an edge: abort to IDLE, no write.
- READY:
  - `Pready`=1. `Prdata` = mem[latched addr] for an in-range read, otherwise 0.
  - Edge with `Psel`=`Penable`=1: transfer completes.
    - For a write with no error, mem[latched addr] ← latched wdata.
    - Return to IDLE.
  - `Psel`=0: abort to IDLE, no write.
- Out-of-range access:
  - No register is written.
  - A read returns 0.
  - `Pslverr` behaviour depends on configuration (see Configuration).
- `Penable`=1 seen in IDLE (protocol violation): ignored, remain in IDLE.
- Reset, including in the middle of a transfer:
  - State ← IDLE, counter ← 0, request registers ← 0.
  - `Pready`=0, `Prdata`=0, `Pslverr`=0.
  - All DEPTH registers ← 0.
  - A pending write is discarded.

## Timing
- `Pready`, `Prdata` and `Pslverr` are registered; no combinational path from any input.
- Let S be the setup cycle. `Pready` is high in cycle S+1+WAIT_CYCLES, so each transfer takes WAIT_CYCLES+2 cycles including setup.
- `Pready` is high for exactly one cycle per completed transfer.
- Write data is visible to a read issued in the setup cycle immediately after completion.
- Back-to-back transfers: a setup in the cycle after the completing edge is accepted with no bubble.

## Configuration
- Macro `APB_SLVERR_EN`.
- Defined: `Pslverr` = latched error flag while `Pready`=1, else 0.
- Undefined: `Pslverr` is tied to 0, and out-of-range accesses are silently dropped (read returns 0). No other behaviour changes.

## Structure
- Shared package `apb_pkg`:
  - State enum (IDLE/WAIT/READY).
  - Counter width constant (4 bits).
  - `APB_RDATA_DEFAULT` = 0.
- One natural sub-module, `apb_regfile`:
  - DEPTH×WIDTH array, one synchronous write port, one asynchronous read port, synchronous clear.
  - The FSM, counter and output registers stay in `apb_wait_slave`.

## Test plan
- Reset, then idle: `Pready`=0, `Prdata`=0, `Pslverr`=0. Read of addr 5 returns 0.
- WAIT_CYCLES=2: write 0xDEADBEEF to addr 3 with setup in cycle 10. `Pready` is high only in cycle 13. A following read of addr 3 returns 0xDEADBEEF with `Pready` in cycle 17.
- WAIT_CYCLES=0: write addr 1 = 0x11, then immediately read addr 1 back-to-back. Each transfer is 2 cycles with no bubble; the read returns 0x11.
- `Paddr`=70 with DEPTH=64:
  - With `APB_SLVERR_EN`: a write leaves all registers unchanged, and a read returns 0 with `Pslverr`=1 during `Pready`.
  - Without `APB_SLVERR_EN`: same, except `Pslverr`=0.
- Abort: write 0x55 to addr 2 and drop `Psel` during WAIT. State returns to IDLE; a later read of addr 2 returns the old value.
- Reset asserted during READY of a write: no commit, all outputs 0 next cycle, all registers read back 0.
